bit_word_packer: RTL and testbench
==================================

# bit_word_packer

Snapshots a wide vector of single-bit netlist signals and streams it out as fixed-width words over a valid/ready handshake, LSB word first. It is the collecting end of the wide-bus-to-scalar fan-out used in the netlist backend test designs: the fan-out block spreads 32-bit buses across up to 200 scalar outputs, and this block gathers those scalars back into 32-bit words for a downstream consumer or checker.

## Interface
- `NBITS`, 200: width of the captured scalar vector, ≥1.
- `WIDTH`, 32: output word width, ≥1.
- `CNTW`, 8: width of the dropped-capture counter.
- Derived constant `NWORDS` = ceil(`NBITS`/`WIDTH`); 7 at defaults.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `capture`, in, 1: request to snapshot `bits`.
- `bits`, in, `NBITS`: scalar signals. Bit k is the signal numbered k (`o_k`).
- `out_data`, out, `WIDTH`: current word.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: consumer accepts the word.
- `out_last`, out, 1: current word is word `NWORDS`-1.
- `out_idx`, out, clog2(`NWORDS`): index of the current word.
- `busy`, out, 1: a frame is being sent.
- `drop_cnt`, out, `CNTW`: saturating count of ignored captures.

## Operation
- States: IDLE and SEND.
- Reset values: state IDLE. `out_valid`, `out_last`, `busy` = 0. `out_idx` = 0. `out_data` = 0. `drop_cnt` = 0. Snapshot register = 0.
- IDLE with `capture`=1:
  - Latch `bits` into the snapshot register.
  - Set `out_idx` = 0 and go to SEND.
- SEND:
  - `out_valid` = `busy` = 1.
  - `out_data` = snapshot[`out_idx`*`WIDTH` +: `WIDTH`].
  - Bits at positions ≥ `NBITS` read as 0. At defaults, word 6 carries bits 192..199 in [7:0] and [31:8] = 0.
- Handshake: a word transfers when `out_valid` & `out_ready`.
  - `out_data`, `out_idx` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never drops without a transfer.
- Transfer of a non-last word: `out_idx` increments.
- Transfer of the last word:
  - If `capture`=1 in the same cycle: new snapshot, `out_idx` = 0, stay in SEND (back-to-back frames, no bubble).
  - Otherwise go to IDLE.
- `capture`=1 in SEND, except on a last-word transfer cycle:
  - The capture is ignored and the snapshot is unchanged.
  - `drop_cnt` increments, saturating at 2^`CNTW`-1.
- `bits` is sampled only on an accepted capture edge. Changes at any other time have no effect.
- Reset asserted mid-frame: all state clears immediately, the frame is abandoned, and no partial word is emitted after release.
- `NWORDS`=1: every transfer is a last-word transfer.

## Timing
- Accepted capture at edge N: first word valid after edge N, at cycle N+1.
- With `out_ready` held at 1, a frame takes `NWORDS` cycles.
- `busy` falls the cycle after the last transfer unless the frame is reloaded.
- Throughput: one word per cycle. Next-capture latency after return to IDLE: 1 cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- `packer_pkg` holds:
  - the state enum (IDLE, SEND);
  - the `NWORDS` ceiling-divide function;
  - the clog2-based index width helper.
- Sub-module `packer_word_sel`: combinational word select from the zero-padded snapshot, selected by `out_idx`.
- FSM, counters and handshake live in the top module.

## Test plan
- Reset, then capture with `bits` = 200'h1 followed by 192 zeros...FF:
  - word0 = 32'h00000001, words 1..5 = 0;
  - word6 = 32'h000000FF with `out_last`=1;
  - 7 cycles with ready=1; `busy`=0 on cycle 8.
- `out_ready` toggles 1,0,0,1,...: each word is held stable while ready=0; indices 0..6 each appear exactly once, in order.
- 3 captures during a frame: `drop_cnt`=3 and the snapshot is unchanged. With `CNTW`=2, 5 drops leaves `drop_cnt`=3 (saturated).
- Capture asserted on the last-word transfer: the next cycle shows word0 of the new vector with `out_idx`=0, and `busy` stays 1.
- `rst_n` pulsed low at `out_idx`=3:
  - all outputs are 0 asynchronously, before the next edge;
  - no `out_valid` until a new capture, which is then fully emitted starting at word0.
- `NBITS`=64, `WIDTH`=32: 2 words, `out_last` on word1, no padding.

Source files
------------

// File: rtl/bit_word_packer_pkg.sv
// Shared types and sizing helpers for the bit-to-word packer.
package packer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int nwords_f(input int nbits, input int width);
        return (nbits + width - 1) / width;
    endfunction

    // A single-word frame still needs a one-bit index port.
    function automatic int idx_w_f(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/bit_word_packer_word_sel.sv
// Combinational word select from the zero-padded snapshot.
module packer_word_sel
    import packer_pkg::*;
#(
    parameter int NBITS  = 200,
    parameter int WIDTH  = 32,
    parameter int NWORDS = nwords_f(NBITS, WIDTH),
    parameter int IDXW   = idx_w_f(NWORDS)
) (
    input  logic [NBITS-1:0] snap,
    input  logic [IDXW-1:0]  idx,
    output logic [WIDTH-1:0] word
);

    localparam int PADW = NWORDS * WIDTH;

    logic [PADW-1:0]  padded;
    logic [WIDTH-1:0] words [NWORDS];

    generate
        if (PADW > NBITS) begin : g_pad
            assign padded = {{(PADW - NBITS){1'b0}}, snap};
        end else begin : g_nopad
            assign padded = snap;
        end

        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
            assign words[gi] = padded[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Indices past the last word select zero rather than wrapping.
    always_comb begin
        word = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx == IDXW'(i)) begin
                word = words[i];
            end
        end
    end

endmodule

// File: rtl/bit_word_packer.sv
// Snapshots a wide scalar vector and streams it out LSB word first over valid/ready.
module bit_word_packer
    import packer_pkg::*;
#(
    parameter  int NBITS  = 200,
    parameter  int WIDTH  = 32,
    parameter  int CNTW   = 8,
    localparam int NWORDS = nwords_f(NBITS, WIDTH),
    localparam int IDXW   = idx_w_f(NWORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic [NBITS-1:0] bits,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [IDXW-1:0]  out_idx,
    output logic             busy,
    output logic [CNTW-1:0]  drop_cnt
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;

    state_t           state_reg;
    logic [NBITS-1:0] snap_reg;
    logic [NBITS-1:0] snap_sel;
    logic [IDXW-1:0]  idx_sel;
    logic [WIDTH-1:0] word_sel;
    logic             xfer;
    logic             load;
    logic             advance;
    logic             drop;

    // The selector looks at the post-edge snapshot/index so out_data can be registered.
    always_comb begin
        xfer     = out_valid & out_ready;
        load     = capture & ((state_reg == IDLE) | (xfer & out_last));
        advance  = xfer & ~out_last;
        drop     = capture & (state_reg == SEND) & ~(xfer & out_last);
        snap_sel = load ? bits : snap_reg;
        idx_sel  = load ? '0 : (advance ? out_idx + IDXW'(1) : out_idx);
    end

    packer_word_sel #(
        .NBITS  (NBITS),
        .WIDTH  (WIDTH),
        .NWORDS (NWORDS),
        .IDXW   (IDXW)
    ) u_word_sel (
        .snap (snap_sel),
        .idx  (idx_sel),
        .word (word_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            snap_reg  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            busy      <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (drop && drop_cnt != CNT_MAX) begin
                drop_cnt <= drop_cnt + CNTW'(1);
            end

            if (load) begin
                state_reg <= SEND;
                snap_reg  <= bits;
                out_valid <= 1'b1;
                busy      <= 1'b1;
                out_idx   <= '0;
                out_last  <= (LAST_IDX == '0);
                out_data  <= word_sel;
            end else if (xfer && out_last) begin
                state_reg <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                out_idx   <= '0;
                out_last  <= 1'b0;
                out_data  <= '0;
            end else if (advance) begin
                out_idx   <= idx_sel;
                out_last  <= (idx_sel == LAST_IDX);
                out_data  <= word_sel;
            end
        end
    end

endmodule

// File: tb/tb_bit_word_packer.sv
// Directed bench for bit_word_packer: default 200x32 instance plus a 64-bit, 2-bit-counter instance.
module tb_bit_word_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b1;
    logic         capture;
    logic         out_ready;
    logic [199:0] bits;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_last;
    logic [2:0]   out_idx;
    logic         busy;
    logic [7:0]   drop_cnt;

    logic         s_capture;
    logic         s_ready;
    logic [63:0]  s_bits;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_last;
    logic [0:0]   s_idx;
    logic         s_busy;
    logic [1:0]   s_drop;

    bit_word_packer u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (capture),
        .bits      (bits),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    bit_word_packer #(.NBITS(64), .WIDTH(32), .CNTW(2)) u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (s_capture),
        .bits      (s_bits),
        .out_data  (s_data),
        .out_valid (s_valid),
        .out_ready (s_ready),
        .out_last  (s_last),
        .out_idx   (s_idx),
        .busy      (s_busy),
        .drop_cnt  (s_drop)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Hand-written expected words for the two test vectors.
    logic [199:0] bits_a;
    logic [199:0] bits_b;
    logic [31:0]  exp_a [7] = '{32'h00000001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000000FF};
    logic [31:0]  exp_b [7] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                32'h55555555, 32'h66666666, 32'h000000C3};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %s: %0h", tag, obs);
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit use_b, input string tag);
        out_ready = 1'b1;
        for (int w = 0; w < 7; w++) begin
            check($sformatf("%s_valid%0d", tag, w), 64'(out_valid), 64'd1);
            check($sformatf("%s_idx%0d", tag, w), 64'(out_idx), 64'(w));
            check($sformatf("%s_data%0d", tag, w), 64'(out_data), 64'(use_b ? exp_b[w] : exp_a[w]));
            check($sformatf("%s_last%0d", tag, w), 64'(out_last), 64'(w == 6));
            tick();
        end
        check({tag, "_end_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_end_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_idx;

        bits_a = '0;
        bits_a[0] = 1'b1;
        bits_a[199:192] = 8'hFF;
        bits_b = {8'hC3, 32'h66666666, 32'h55555555, 32'h44444444,
                  32'h33333333, 32'h22222222, 32'h11111111};

        capture   = 1'b0;
        out_ready = 1'b0;
        bits      = '0;
        s_capture = 1'b0;
        s_ready   = 1'b0;
        s_bits    = '0;

        // Reset state, observed before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_idx", 64'(out_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Full frame at ready=1.
        bits = bits_a;
        capture = 1'b1;
        out_ready = 1'b1;
        tick();
        capture = 1'b0;
        bits = '1;
        drain(1'b0, "frameA");

        // Ready toggling 1,0,0: each word must hold until accepted.
        out_ready = 1'b0;
        bits = bits_b;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        exp_idx = 0;
        for (int c = 0; c < 40 && exp_idx < 7; c++) begin
            check("tog_valid", 64'(out_valid), 64'd1);
            check("tog_idx", 64'(out_idx), 64'(exp_idx));
            check("tog_data", 64'(out_data), 64'(exp_b[exp_idx]));
            out_ready = (c % 3 == 0);
            tick();
            if (out_ready) exp_idx++;
        end
        check("tog_count", 64'(exp_idx), 64'd7);
        out_ready = 1'b0;
        check("tog_end_valid", 64'(out_valid), 64'd0);
        check("tog_end_busy", 64'(busy), 64'd0);

        // Three captures mid-frame are dropped; snapshot keeps vector B.
        bits = bits_b;
        capture = 1'b1;
        tick();
        bits = '1;
        for (int k = 0; k < 3; k++) begin
            capture = 1'b1;
            tick();
            capture = 1'b0;
            tick();
        end
        check("drop_cnt3", 64'(drop_cnt), 64'd3);
        drain(1'b1, "dropB");

        // Capture on the last-word transfer reloads with no bubble.
        bits = bits_a;
        capture = 1'b1;
        out_ready = 1'b1;
        tick();
        capture = 1'b0;
        for (int w = 0; w < 6; w++) begin
            check("b2b_idx", 64'(out_idx), 64'(w));
            tick();
        end
        check("b2b_last_flag", 64'(out_last), 64'd1);
        check("b2b_last_data", 64'(out_data), 64'h000000FF);
        bits = bits_b;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        check("b2b_new_idx", 64'(out_idx), 64'd0);
        check("b2b_new_data", 64'(out_data), 64'h11111111);
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_valid", 64'(out_valid), 64'd1);
        check("b2b_new_last", 64'(out_last), 64'd0);
        tick();
        for (int w = 1; w < 7; w++) begin
            check("b2b_rest", 64'(out_data), 64'(exp_b[w]));
            tick();
        end
        check("b2b_end_valid", 64'(out_valid), 64'd0);
        check("b2b_drop_kept", 64'(drop_cnt), 64'd3);

        // Asynchronous reset at out_idx=3 abandons the frame.
        bits = bits_b;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        repeat (3) tick();
        check("mid_idx3", 64'(out_idx), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_data", 64'(out_data), 64'd0);
        check("arst_idx", 64'(out_idx), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_last", 64'(out_last), 64'd0);
        check("arst_drop", 64'(drop_cnt), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_valid", 64'(out_valid), 64'd0);
        end
        bits = bits_a;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        drain(1'b0, "postA");

        // Small instance: 64 bits, two unpadded words, 2-bit saturating drops.
        s_bits = 64'hDEADBEEF_01234567;
        s_capture = 1'b1;
        tick();
        s_bits = '0;
        repeat (5) tick();
        s_capture = 1'b0;
        check("s_drop_sat", 64'(s_drop), 64'd3);
        check("s_valid0", 64'(s_valid), 64'd1);
        check("s_idx0", 64'(s_idx), 64'd0);
        check("s_data0", 64'(s_data), 64'h01234567);
        check("s_last0", 64'(s_last), 64'd0);
        s_ready = 1'b1;
        tick();
        check("s_idx1", 64'(s_idx), 64'd1);
        check("s_data1", 64'(s_data), 64'hDEADBEEF);
        check("s_last1", 64'(s_last), 64'd1);
        tick();
        check("s_end_valid", 64'(s_valid), 64'd0);
        check("s_end_busy", 64'(s_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
